// File: rtl/modinv_helper_xfer_if.sv
// Operand-transfer bus: start handshake, source read port and destination write port.
interface modinv_helper_xfer_if #(
  parameter int unsigned OPERAND_ADDR_BITS = 3,
  parameter int unsigned BUFFER_ADDR_BITS  = 4,
  parameter int unsigned WORD_WIDTH        = 32
);
  logic                         ena;
  logic [1:0]                   mode;
  logic                         rdy;
  logic                         carry_out;
  logic [BUFFER_ADDR_BITS-1:0]  s_addr;
  logic [WORD_WIDTH-1:0]        s_din;
  logic [OPERAND_ADDR_BITS-1:0] d_addr;
  logic                         d_wren;
  logic [WORD_WIDTH-1:0]        d_dout;

  modport master (
    output ena, mode, s_din,
    input  rdy, carry_out, s_addr, d_addr, d_wren, d_dout
  );

  modport slave (
    input  ena, mode, s_din,
    output rdy, carry_out, s_addr, d_addr, d_wren, d_dout
  );
endinterface

// File: rtl/modinv_helper_xfer.sv
// Copies an operand from a latency-L source buffer into a destination bank,
// optionally clearing, complementing or shifting it left by one bit.
module modinv_helper_xfer #(
  parameter int unsigned OPERAND_NUM_WORDS = 8,
  parameter int unsigned OPERAND_ADDR_BITS = 3,
  parameter int unsigned BUFFER_NUM_WORDS  = 9,
  parameter int unsigned BUFFER_ADDR_BITS  = 4,
  parameter int unsigned WORD_WIDTH        = 32,
  parameter int unsigned READ_LATENCY      = 1
) (
  input logic                clk,
  input logic                rst_n,
  modinv_helper_xfer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(OPERAND_NUM_WORDS + READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_N     = CNT_W'(OPERAND_NUM_WORDS);
  localparam logic [CNT_W-1:0] CNT_WR0   = CNT_W'(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OPERAND_NUM_WORDS + READ_LATENCY);

  typedef enum logic [1:0] {
    MODE_COPY  = 2'b00,
    MODE_CLEAR = 2'b01,
    MODE_SHL1  = 2'b10,
    MODE_NOT   = 2'b11
  } mode_e;

  // Elaboration-time sanity on the buffer geometry
  if (BUFFER_NUM_WORDS < OPERAND_NUM_WORDS) begin : g_bad_buffer
    $error("source buffer smaller than operand");
  end

  logic [CNT_W-1:0]             proc_cnt, cnt_nxt;
  mode_e                        mode_q, mode_nxt;
  logic                         shift_c, shift_c_nxt;
  logic                         carry_q, carry_nxt;
  logic [BUFFER_ADDR_BITS-1:0]  s_addr_q, s_addr_nxt;
  logic [OPERAND_ADDR_BITS-1:0] d_addr_q, d_addr_nxt;
  logic                         wren_c;
  logic [WORD_WIDTH-1:0]        dout_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proc_cnt <= '0;
      mode_q   <= MODE_COPY;
      shift_c  <= 1'b0;
      carry_q  <= 1'b0;
      s_addr_q <= '0;
      d_addr_q <= '0;
    end else begin
      proc_cnt <= cnt_nxt;
      mode_q   <= mode_nxt;
      shift_c  <= shift_c_nxt;
      carry_q  <= carry_nxt;
      s_addr_q <= s_addr_nxt;
      d_addr_q <= d_addr_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    cnt_nxt     = proc_cnt;
    mode_nxt    = mode_q;
    shift_c_nxt = shift_c;
    carry_nxt   = carry_q;
    s_addr_nxt  = '0;
    d_addr_nxt  = '0;
    wren_c      = (proc_cnt >= CNT_WR0) && (proc_cnt <= CNT_LAST);
    dout_c      = bus.s_din;

    if (proc_cnt == '0) begin
      if (bus.ena) begin
        cnt_nxt     = CNT_ONE;
        mode_nxt    = mode_e'(bus.mode);
        shift_c_nxt = 1'b0;
      end
    end else if (proc_cnt == CNT_LAST) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = proc_cnt + CNT_ONE;
    end

    // MSB of the word being written feeds the next word's LSB
    if (wren_c) begin
      shift_c_nxt = bus.s_din[WORD_WIDTH-1];
    end

    if (proc_cnt == CNT_LAST) begin
      carry_nxt = (mode_q == MODE_SHL1) ? bus.s_din[WORD_WIDTH-1] : 1'b0;
    end

    if ((cnt_nxt >= CNT_ONE) && (cnt_nxt <= CNT_N) && (mode_nxt != MODE_CLEAR)) begin
      s_addr_nxt = BUFFER_ADDR_BITS'(cnt_nxt - CNT_ONE);
    end

    if ((cnt_nxt >= CNT_WR0) && (cnt_nxt <= CNT_LAST)) begin
      d_addr_nxt = OPERAND_ADDR_BITS'(cnt_nxt - CNT_WR0);
    end

    case (mode_q)
      MODE_COPY:  dout_c = bus.s_din;
      MODE_CLEAR: dout_c = '0;
      MODE_SHL1:  dout_c = {bus.s_din[WORD_WIDTH-2:0], shift_c};
      MODE_NOT:   dout_c = ~bus.s_din;
      default:    dout_c = bus.s_din;
    endcase
  end

  assign bus.rdy       = (proc_cnt == '0);
  assign bus.carry_out = carry_q;
  assign bus.s_addr    = s_addr_q;
  assign bus.d_addr    = d_addr_q;
  assign bus.d_wren    = wren_c;
  assign bus.d_dout    = dout_c;

endmodule
